dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, width of the word address driven to data memory.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 c_req, d_req  in  1 each  access request from CPU port (c_) and debug/loader port (d_).
REQ-005 c_we, d_we  in  1 each  1 = store, 0 = load.
REQ-006 c_size, d_size  in  2 each  00 byte, 01 half, 10 word; 11 illegal.
REQ-007 c_addr, d_addr  in  32 each  byte address.
REQ-008 c_wdata, d_wdata  in  32 each  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-009 c_ack, d_ack  out  1 each  one-cycle completion pulse.
REQ-010 c_err, d_err  out  1 each  valid with ack; 1 = misaligned/illegal access, no memory effect.
REQ-011 c_rdata, d_rdata  out  32 each  load result, right-aligned, zero-extended; valid with ack.
REQ-012 mem_en  out  1; mem_we  out  1; mem_be  out  4; mem_addr  out  MEM_AW; mem_wdata  out  32; mem_rdata  in  32 (memory returns read data one cycle after mem_en).

Function
REQ-013 Requester holds req and all request fields stable from assertion until the cycle its ack is high; requester drops req or presents a new request the cycle after ack.
REQ-014 FSM states: IDLE, ACCESS, RESP.
REQ-015 IDLE: if any req, select winner, latch its fields and a grant id, go ACCESS; else stay IDLE.
REQ-016 Selection: single req wins; both req -> requester not granted last (round-robin pointer); pointer resets to "last = debug" so CPU wins first tie.
REQ-017 ACCESS: if aligned and legal, mem_en=1 for exactly this cycle with mem_we, mem_be, mem_addr=addr[MEM_AW+1:2], lane-shifted mem_wdata; go RESP.
REQ-018 ACCESS with misalignment (half with addr[0]=1, word with addr[1:0]!=0, size=11): mem_en=0, go RESP with error flag set.
REQ-019 mem_be: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111; mem_be also driven for loads.
REQ-020 mem_wdata: byte data replicated/shifted to lane addr[1:0]; half to lane addr[1]; word unchanged.
REQ-021 RESP: pulse winner's ack; err as latched; rdata = mem_rdata shifted down by addr[1:0]*8 and masked to size (0 for stores and errors); non-winner ack stays 0.
REQ-022 RESP -> ACCESS directly if the other requester's req is high (it wins), else IDLE; the just-served requester cannot be regranted back-to-back while the other waits.
REQ-023 Latency: req seen in IDLE at cycle N -> mem_en at N+1 -> ack at N+2; max one access per 2 cycles under contention.
REQ-024 Starvation bound: a held req is acked within 4 cycles of the other requester's ack.
REQ-025 mem_en, ack and err never asserted in IDLE; at most one ack high per cycle.
REQ-026 A req deasserted before ack (protocol violation) does not abort a latched access; the access completes and ack is still pulsed.

Reset
REQ-027 rst high at a clock edge: state=IDLE, rr pointer=debug, latched fields cleared, all outputs 0 next cycle, including mid-ACCESS/RESP (in-flight access dropped, no ack).
REQ-028 Requests sampled only in cycles after rst is low.

Verification
REQ-029 CPU store word 0xDEADBEEF to 0x10, then load -> mem_be=1111, mem_addr=4; ack at N+2; c_rdata=0xDEADBEEF.
REQ-030 CPU store byte 0xAB to 0x13 then load half from 0x12 -> mem_be 1000 then 1100; c_rdata=0x0000AB00 masked/shifted as 0x0000ABxx per prior contents.
REQ-031 Half store to 0x01 -> c_ack=1, c_err=1, mem_en never 1, memory unchanged.
REQ-032 c_req and d_req held together for 8 cycles -> acks alternate CPU, debug, CPU, debug at 2-cycle spacing, CPU first after reset.
REQ-033 rst asserted in ACCESS cycle -> no ack follows; next cycle all outputs 0; fresh d_req completes normally.
REQ-034 Load byte from 0x07 after word 0x11223344 stored at 0x04 -> d_rdata=0x00000011.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU and debug/loader share one single-port
// word memory. Round-robin on ties, lane steering for byte/half accesses,
// misaligned or illegal accesses complete with err and no memory effect.
module dmem_arbiter #(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [1:0]        c_size,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_ack,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  // Round-robin pointer: 1 means the debug port was granted most recently.
  logic        last_dbg;

  // Latched request of the current winner.
  logic        gnt_dbg;
  logic        q_we;
  logic [1:0]  q_size;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;
  logic        q_err;

  logic        grant;
  logic        grant_dbg;
  logic        bad;
  logic [31:0] shifted;
  logic [31:0] rdata_v;

  // Upper address bits lie outside the memory window and are ignored.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^q_addr[31:MEM_AW+2];

  // Misaligned half/word or the reserved size encoding.
  assign bad = (q_size == 2'b11) ||
               ((q_size == 2'b01) && q_addr[0]) ||
               ((q_size == 2'b10) && (q_addr[1:0] != 2'b00));

  // State register, round-robin pointer and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_dbg <= 1'b1;
      gnt_dbg  <= 1'b0;
      q_we     <= 1'b0;
      q_size   <= '0;
      q_addr   <= '0;
      q_wdata  <= '0;
      q_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        gnt_dbg  <= grant_dbg;
        last_dbg <= grant_dbg;
        q_we     <= grant_dbg ? d_we    : c_we;
        q_size   <= grant_dbg ? d_size  : c_size;
        q_addr   <= grant_dbg ? d_addr  : c_addr;
        q_wdata  <= grant_dbg ? d_wdata : c_wdata;
        q_err    <= 1'b0;
      end
      if (state == ACCESS) begin
        q_err <= bad;
      end
    end
  end

  // Next state and grant decision. In RESP only the other requester is
  // considered, so the one being acked cannot be regranted back-to-back.
  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_dbg = 1'b0;
    case (state)
      IDLE: begin
        if (c_req && d_req) begin
          grant     = 1'b1;
          grant_dbg = ~last_dbg;
        end else if (c_req) begin
          grant     = 1'b1;
          grant_dbg = 1'b0;
        end else if (d_req) begin
          grant     = 1'b1;
          grant_dbg = 1'b1;
        end
        if (grant) begin
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        state_nx = RESP;
      end
      RESP: begin
        if (gnt_dbg ? c_req : d_req) begin
          grant     = 1'b1;
          grant_dbg = ~gnt_dbg;
          state_nx  = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Load data alignment: shift the addressed lane down and mask to size.
  always_comb begin
    shifted = mem_rdata >> {q_addr[1:0], 3'b000};
    case (q_size)
      2'b00:   rdata_v = {24'h0, shifted[7:0]};
      2'b01:   rdata_v = {16'h0, shifted[15:0]};
      default: rdata_v = shifted;
    endcase
  end

  // Memory-side and requester-side outputs, all zero outside ACCESS/RESP.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    c_ack     = 1'b0;
    c_err     = 1'b0;
    c_rdata   = '0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;
    if ((state == ACCESS) && !bad) begin
      mem_en   = 1'b1;
      mem_we   = q_we;
      mem_addr = q_addr[MEM_AW+1:2];
      case (q_size)
        2'b00: begin
          mem_be    = 4'b0001 << q_addr[1:0];
          mem_wdata = {4{q_wdata[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << q_addr[1:0];
          mem_wdata = {2{q_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = q_wdata;
        end
      endcase
    end
    if (state == RESP) begin
      if (gnt_dbg) begin
        d_ack = 1'b1;
        d_err = q_err;
        if (!q_we && !q_err) begin
          d_rdata = rdata_v;
        end
      end else begin
        c_ack = 1'b1;
        c_err = q_err;
        if (!q_we && !q_err) begin
          c_rdata = rdata_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read word memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [1:0]    c_size, d_size;
  logic [31:0]   c_addr, c_wdata, d_addr, d_wdata;
  logic          c_ack, c_err, d_ack, d_err;
  logic [31:0]   c_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data appears one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access from one port; called right after a negedge.
  task automatic do_access(input string tag, input bit dbg, input logic we,
                           input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit exp_en,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic exp_err, input logic [31:0] exp_rd);
    logic [31:0] lane_mask;
    lane_mask = '0;
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{exp_be[i]}};
    if (dbg) begin
      d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_size = size; c_addr = addr; c_wdata = wdata;
    end
    @(negedge clk);
    check({tag, "_en"}, 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      check({tag, "_we"}, 32'(mem_we), 32'(we));
      check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
      check({tag, "_maddr"}, 32'(mem_addr), 32'(addr[AW+1:2]));
      if (we) check({tag, "_wdata"}, mem_wdata & lane_mask, exp_wd);
    end
    check({tag, "_ack_early"}, {30'h0, c_ack, d_ack}, 32'h0);
    @(negedge clk);
    check({tag, "_ack"}, {30'h0, c_ack, d_ack}, dbg ? 32'h1 : 32'h2);
    check({tag, "_err"}, 32'(dbg ? d_err : c_err), 32'(exp_err));
    check({tag, "_rdata"}, dbg ? d_rdata : c_rdata, exp_rd);
    check({tag, "_en_resp"}, 32'(mem_en), 32'h0);
    c_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {29'h0, c_ack, d_ack, mem_en}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem_rdata = '0;
    rst = 1'b1;
    c_req = 0; c_we = 0; c_size = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ctl", {24'h0, mem_en, mem_we, mem_be, c_ack, d_ack}, 32'h0);
    check("rst_err", {30'h0, c_err, d_err}, 32'h0);
    check("rst_maddr", 32'(mem_addr), 32'h0);
    check("rst_mwdata", mem_wdata, 32'h0);
    check("rst_rdata", c_rdata | d_rdata, 32'h0);

    // Word store/load at 0x10.
    do_access("sw10", 0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    do_access("lw10", 0, 0, 2'b10, 32'h10, 32'h0, 1, 4'hF, 32'h0, 0, 32'hDEADBEEF);
    // Byte store to lane 3, then half load of the upper lanes.
    do_access("sb13", 0, 1, 2'b00, 32'h13, 32'hAB, 1, 4'h8, 32'hAB000000, 0, 32'h0);
    do_access("lh12", 0, 0, 2'b01, 32'h12, 32'h0, 1, 4'hC, 32'h0, 0, 32'h0000ABAD);
    // Error cases: no memory access, err returned with ack.
    do_access("sh01", 0, 1, 2'b01, 32'h01, 32'h1234, 0, 4'h0, 32'h0, 1, 32'h0);
    check("sh01_mem", mem[0], 32'h0);
    do_access("lw06", 0, 0, 2'b10, 32'h06, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0);
    do_access("sz11", 1, 0, 2'b11, 32'h00, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0);
    // Debug port: word store, then sub-word loads.
    do_access("dsw04", 1, 1, 2'b10, 32'h04, 32'h11223344, 1, 4'hF, 32'h11223344, 0, 32'h0);
    do_access("dlb07", 1, 0, 2'b00, 32'h07, 32'h0, 1, 4'h8, 32'h0, 0, 32'h00000011);
    do_access("dlh06", 1, 0, 2'b01, 32'h06, 32'h0, 1, 4'hC, 32'h0, 0, 32'h00001122);
    do_access("clb05", 0, 0, 2'b00, 32'h05, 32'h0, 1, 4'h2, 32'h0, 0, 32'h00000033);
    do_access("csh02", 0, 1, 2'b01, 32'h02, 32'h5566, 1, 4'hC, 32'h55660000, 0, 32'h0);
    check("csh02_mem", mem[0], 32'h55660000);

    // Request withdrawn after being latched still completes.
    c_req = 1; c_we = 0; c_size = 2'b10; c_addr = 32'h04;
    @(negedge clk);
    c_req = 0;
    check("drop_en", 32'(mem_en), 32'h1);
    @(negedge clk);
    check("drop_ack", 32'(c_ack), 32'h1);
    check("drop_rdata", c_rdata, 32'h11223344);

    // Reset during ACCESS drops the access.
    @(negedge clk);
    c_req = 1; c_we = 0; c_size = 2'b10; c_addr = 32'h10;
    @(negedge clk);
    check("rsta_en", 32'(mem_en), 32'h1);
    rst = 1'b1;
    c_req = 0;
    @(negedge clk);
    rst = 1'b0;
    check("rsta_out", {24'h0, mem_en, mem_we, mem_be, c_ack, d_ack}, 32'h0);
    check("rsta_data", c_rdata | d_rdata | mem_wdata | 32'(mem_addr), 32'h0);
    @(negedge clk);
    check("rsta_noack", {30'h0, c_ack, d_ack}, 32'h0);
    do_access("rsta_dlw", 1, 0, 2'b10, 32'h10, 32'h0, 1, 4'hF, 32'h0, 0, 32'hABADBEEF);

    // Contention from reset: CPU first, then alternate every 2 cycles.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c_req = 1; c_we = 0; c_size = 2'b10; c_addr = 32'h10;
    d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 32'h04;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rr_cack%0d", k), 32'(c_ack), 32'((k == 2) || (k == 6)));
      check($sformatf("rr_dack%0d", k), 32'(d_ack), 32'((k == 4) || (k == 8)));
      if (k == 2) check("rr_crdata", c_rdata, 32'hABADBEEF);
      if (k == 4) check("rr_drdata", d_rdata, 32'h11223344);
    end
    c_req = 0;
    d_req = 0;
    @(negedge clk);
    check("rr_end", {29'h0, c_ack, d_ack, mem_en}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
